card_grid_renderer: RTL and testbench
=====================================

Name: card_grid_renderer

Overview:
- Registered, parametrised card sprite renderer for the VGA memory-game display.
- Places one card in a ROWS x COLS grid and draws the face from an external ROM or a solid back colour.
- Adds a frame-synchronous flip animation (horizontal close/open), a selection highlight border and a busy/done handshake.
- Sits between the VGA sync counter and the pixel mux; one instance per card slot.

Parameters:
- CARD_W, 83, card width in pixels
- CARD_H, 83, card height in pixels
- COLS, 4, grid columns
- ROWS, 4, grid rows
- X0, 130, left edge of column 0
- Y0, 70, top edge of row 0
- PITCH_X, 100, horizontal distance between column origins
- PITCH_Y, 100, vertical distance between row origins
- SHRINK_STEP, 6, columns clipped per side per frame_tick during a flip
- BORDER, 2, highlight border thickness in pixels
- BACK_RGB, 3'b001, face-down colour
- HILITE_RGB, 3'b110, highlight border colour
- PW, 4, pos width, clog2(ROWS*COLS)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blank
- HCount  in  10  current pixel column
- VCount  in  10  current pixel row
- pos  in  PW  grid slot index, row-major
- selected  in  1  draw highlight border
- flip_req  in  1  request a face flip
- busy  out  1  flip animation in progress
- done  out  1  one-cycle pulse when a flip completes
- face_up  out  1  current stable face, 1 = ROM face
- rom_addr  out  7  ROM row address, VCount - y_t
- rom_data  in  3*CARD_W  ROM row, pixel c at bits [3c+2:3c]
- cardon  out  1  pixel belongs to the card
- rgb  out  3  pixel colour

Behaviour:
- Reset (async, rst_n=0): state=DOWN, shrink=0, busy=0, done=0, face_up=0, cardon=0, rgb=0, pipeline registers cleared.
- Geometry:
  - row = pos / COLS, col = pos % COLS.
  - x_l = X0 + col*PITCH_X, y_t = Y0 + row*PITCH_Y.
  - x_r = x_l + CARD_W - 1, y_b = y_t + CARD_H - 1.
  - All arithmetic is 10-bit unsigned. pos >= ROWS*COLS means cardon=0 and rgb=0.
- Pipeline, latency 2 clocks from HCount/VCount to cardon/rgb:
  - Stage 1 registers in_box, local column c = HCount - x_l, and rom_addr = VCount - y_t. rom_addr is driven from the stage-1 register; the ROM is combinational.
  - Stage 2 registers cardon and rgb.
- Visibility: stage 2 asserts cardon only when in_box and shrink <= c <= CARD_W-1-shrink. Otherwise cardon=0 and rgb=0.
- Colour priority, when visible:
  1. selected=1, state in {DOWN, UP}, and the pixel lies within BORDER of any card edge: HILITE_RGB.
  2. Displayed face is up: rom_data[3c+2:3c].
  3. Otherwise: BACK_RGB.
- Displayed face: DOWN and CLOSE_D show the back; OPEN_U, UP and CLOSE_U show the ROM face; OPEN_D shows the back.
- FSM (states DOWN, CLOSE_D, OPEN_U, UP, CLOSE_U, OPEN_D):
  - DOWN, flip_req=1 -> CLOSE_D, busy=1.
  - UP, flip_req=1 -> CLOSE_U, busy=1.
  - CLOSE_x: on each frame_tick, shrink += SHRINK_STEP. If the result is >= CARD_W/2 (41), shrink = 41 and move to OPEN_ (the other face).
  - OPEN_x: on each frame_tick, if shrink <= SHRINK_STEP then shrink = 0, move to the stable state of that face, busy=0, face_up updated, done=1 for exactly one clock. Otherwise shrink -= SHRINK_STEP.
- Boundary and corner cases:
  - flip_req is ignored while busy=1; it is not queued.
  - flip_req and frame_tick in the same cycle in a stable state: only the transition happens; the first shrink step waits for the next frame_tick.
  - pos or selected changing mid-animation takes effect on the next pixel; animation state is unaffected.
  - Reset mid-flip returns to DOWN with shrink=0 immediately.
  - frame_tick in a stable state has no effect.

Test Plan:
1. Reset, pos=5, HCount=230, VCount=170 -> two clocks later cardon=1, rgb=3'b001, rom_addr=0.
2. pos=15, pixel (512,452) -> cardon=1. Pixel (513,452) -> cardon=0. pos=15 with pixel (130,70) -> cardon=0.
3. selected=1, pos=0, pixel (131,100) -> rgb=3'b110; pixel (135,100) -> rgb=3'b001.
4. flip_req pulse in DOWN, then 14 frame_ticks:
   - shrink sequence 6,12,18,24,30,36,41,35,29,23,17,11,5,0.
   - At shrink=41 the column at x_l+41 is visible and all others clipped.
   - done pulses once after tick 14; face_up=1, busy=0. Pixel (130+c,70) now returns rom_data[3c+2:3c] (load ROM row 0 with a known pattern).
5. flip_req during busy (after tick 3) -> ignored; completion still occurs at tick 14 with a single done.
6. rst_n low after tick 9 of a flip -> immediately busy=0, face_up=0, cardon=0; after release the card renders BACK_RGB with shrink=0.

Source files
------------

// File: rtl/card_grid_renderer_if.sv
// Signal bundle between the VGA timing/game logic (master) and one card
// slot renderer (slave). The master side also supplies the face ROM row.
interface card_grid_renderer_if #(
    parameter int PW     = 4,
    parameter int CARD_W = 83
);
    logic                  frame_tick;
    logic [9:0]            HCount;
    logic [9:0]            VCount;
    logic [PW-1:0]         pos;
    logic                  selected;
    logic                  flip_req;
    logic                  busy;
    logic                  done;
    logic                  face_up;
    logic [6:0]            rom_addr;
    logic [3*CARD_W-1:0]   rom_data;
    logic                  cardon;
    logic [2:0]            rgb;

    modport master (
        output frame_tick, HCount, VCount, pos, selected, flip_req, rom_data,
        input  busy, done, face_up, rom_addr, cardon, rgb
    );

    modport slave (
        input  frame_tick, HCount, VCount, pos, selected, flip_req, rom_data,
        output busy, done, face_up, rom_addr, cardon, rgb
    );
endinterface

// File: rtl/card_grid_renderer.sv
// Card sprite renderer for one grid slot: places the card from its slot
// index, draws back colour or ROM face, clips columns symmetrically during
// a frame-paced flip animation and overlays a selection border.
module card_grid_renderer #(
    parameter int       CARD_W      = 83,
    parameter int       CARD_H      = 83,
    parameter int       COLS        = 4,
    parameter int       ROWS        = 4,
    parameter int       X0          = 130,
    parameter int       Y0          = 70,
    parameter int       PITCH_X     = 100,
    parameter int       PITCH_Y     = 100,
    parameter int       SHRINK_STEP = 6,
    parameter int       BORDER      = 2,
    parameter bit [2:0] BACK_RGB    = 3'b001,
    parameter bit [2:0] HILITE_RGB  = 3'b110,
    parameter int       PW          = 4
) (
    input logic                clk,
    input logic                rst_n,
    card_grid_renderer_if.slave bus
);
    localparam int NSLOT = ROWS * COLS;
    localparam int HALF  = CARD_W / 2;

    typedef enum logic [2:0] {DOWN, CLOSE_D, OPEN_U, UP, CLOSE_U, OPEN_D} state_t;

    state_t     state;
    logic [6:0] shrink;
    logic [6:0] grown;
    logic       busy;
    logic       done;
    logic       face_up;

    logic [9:0] x_l, y_t, x_r, y_b;
    logic       pos_ok;

    logic       s1_in_box;
    logic [9:0] s1_col;
    logic [6:0] s1_row;
    logic       s1_sel;

    logic       visible;
    logic       on_border;
    logic       show_face;
    logic       stable;
    logic [2:0] pix;
    logic [2:0] rom_pix [CARD_W];

    logic       cardon;
    logic [2:0] rgb;

    // Card rectangle from the row-major slot index (10-bit wraparound arithmetic)
    always_comb begin
        x_l    = 10'(X0 + (int'(bus.pos) % COLS) * PITCH_X);
        y_t    = 10'(Y0 + (int'(bus.pos) / COLS) * PITCH_Y);
        x_r    = x_l + 10'(CARD_W - 1);
        y_b    = y_t + 10'(CARD_H - 1);
        pos_ok = int'(bus.pos) < NSLOT;
    end

    // Stage 1: box test plus card-local column/row; the row doubles as ROM address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_box <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
            s1_sel    <= 1'b0;
        end else begin
            s1_in_box <= pos_ok && (bus.HCount >= x_l) && (bus.HCount <= x_r)
                                && (bus.VCount >= y_t) && (bus.VCount <= y_b);
            s1_col    <= bus.HCount - x_l;
            s1_row    <= 7'(bus.VCount - y_t);
            s1_sel    <= bus.selected;
        end
    end

    // Split the ROM row into per-column pixels so the column lookup is a plain mux
    for (genvar gi = 0; gi < CARD_W; gi++) begin : g_rom_pix
        assign rom_pix[gi] = bus.rom_data[3*gi +: 3];
    end

    assign grown = shrink + 7'(SHRINK_STEP);

    // Stage-2 colour: symmetric clip, then border > face > back priority
    always_comb begin
        visible   = s1_in_box && (s1_col >= 10'(shrink))
                              && (s1_col <= 10'(CARD_W - 1) - 10'(shrink));
        on_border = (s1_col < 10'(BORDER)) || (s1_col > 10'(CARD_W - 1 - BORDER))
                 || (s1_row < 7'(BORDER))  || (s1_row > 7'(CARD_H - 1 - BORDER));
        show_face = (state == OPEN_U) || (state == UP) || (state == CLOSE_U);
        stable    = (state == DOWN) || (state == UP);
        pix       = 3'b000;
        if (visible) begin
            if (s1_sel && stable && on_border) begin
                pix = HILITE_RGB;
            end else if (show_face) begin
                pix = rom_pix[7'(s1_col)];
            end else begin
                pix = BACK_RGB;
            end
        end
    end

    // Stage 2: registered pixel outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cardon <= 1'b0;
            rgb    <= 3'b000;
        end else begin
            cardon <= visible;
            rgb    <= pix;
        end
    end

    // Flip FSM: close to a single column, swap face, reopen; one step per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DOWN;
            shrink  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            face_up <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DOWN: begin
                    if (bus.flip_req) begin
                        state <= CLOSE_D;
                        busy  <= 1'b1;
                    end
                end
                UP: begin
                    if (bus.flip_req) begin
                        state <= CLOSE_U;
                        busy  <= 1'b1;
                    end
                end
                CLOSE_D, CLOSE_U: begin
                    if (bus.frame_tick) begin
                        if (grown >= 7'(HALF)) begin
                            shrink <= 7'(HALF);
                            state  <= (state == CLOSE_D) ? OPEN_U : OPEN_D;
                        end else begin
                            shrink <= grown;
                        end
                    end
                end
                OPEN_U, OPEN_D: begin
                    if (bus.frame_tick) begin
                        if (shrink <= 7'(SHRINK_STEP)) begin
                            shrink  <= '0;
                            state   <= (state == OPEN_U) ? UP : DOWN;
                            busy    <= 1'b0;
                            face_up <= (state == OPEN_U);
                            done    <= 1'b1;
                        end else begin
                            shrink <= shrink - 7'(SHRINK_STEP);
                        end
                    end
                end
                default: state <= DOWN;
            endcase
        end
    end

    assign bus.rom_addr = s1_row;
    assign bus.cardon   = cardon;
    assign bus.rgb      = rgb;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.face_up  = face_up;
endmodule

// File: tb/tb_card_grid_renderer.sv
// Directed bench for card_grid_renderer: geometry, clipping, highlight,
// flip animation timing, busy/done handshake and asynchronous reset.
module tb_card_grid_renderer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   done_cnt;

    card_grid_renderer_if #(.PW(4), .CARD_W(83)) bus ();

    card_grid_renderer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count done pulses, sampled mid-cycle
    always @(negedge clk) if (bus.done === 1'b1) done_cnt = done_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // present a pixel and wait out the two-stage pipeline
    task automatic pix(input int h, input int v);
        bus.HCount = 10'(h);
        bus.VCount = 10'(v);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
    endtask

    task automatic flip();
        bus.flip_req = 1'b1;
        @(posedge clk);
        #1;
        bus.flip_req = 1'b0;
    endtask

    int exp_shrink [14] = '{6, 12, 18, 24, 30, 36, 41, 35, 29, 23, 17, 11, 5, 0};

    initial begin
        logic [3*83-1:0] rom;
        int s;
        int exp_rgb;
        n_cmp = 0;
        n_err = 0;
        done_cnt = 0;
        // ROM row pattern: column c shows colour c mod 8
        for (int c = 0; c < 83; c++) rom[3*c +: 3] = 3'(c % 8);
        bus.rom_data   = rom;
        bus.frame_tick = 1'b0;
        bus.flip_req   = 1'b0;
        bus.selected   = 1'b0;
        bus.pos        = 4'd5;
        bus.HCount     = 10'd230;
        bus.VCount     = 10'd170;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cardon", 32'(bus.cardon), 32'd0);
        chk("rst_rgb", 32'(bus.rgb), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_face_up", 32'(bus.face_up), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // slot 5 = row 1, col 1 -> origin (230,170)
        pix(230, 170);
        chk("p5_cardon", 32'(bus.cardon), 32'd1);
        chk("p5_rgb", 32'(bus.rgb), 32'd1);
        chk("p5_rom_addr", 32'(bus.rom_addr), 32'd0);
        pix(230, 200);
        chk("p5_rom_addr30", 32'(bus.rom_addr), 32'd30);

        // slot 15 = origin (430,370), bottom-right pixel (512,452)
        bus.pos = 4'd15;
        pix(512, 452);
        chk("p15_corner", 32'(bus.cardon), 32'd1);
        pix(513, 452);
        chk("p15_right_out", 32'(bus.cardon), 32'd0);
        pix(512, 453);
        chk("p15_below_out", 32'(bus.cardon), 32'd0);
        pix(130, 70);
        chk("p15_slot0_px", 32'(bus.cardon), 32'd0);
        chk("p15_slot0_rgb", 32'(bus.rgb), 32'd0);

        // highlight border on slot 0
        bus.pos = 4'd0;
        bus.selected = 1'b1;
        pix(131, 100);
        chk("sel_border", 32'(bus.rgb), 32'd6);
        pix(135, 100);
        chk("sel_inner", 32'(bus.rgb), 32'd1);
        pix(212, 100);
        chk("sel_right_edge", 32'(bus.rgb), 32'd6);
        bus.selected = 1'b0;

        // frame_tick while stable: nothing happens
        tick();
        pix(130, 100);
        chk("idle_tick_col0", 32'(bus.cardon), 32'd1);
        chk("idle_tick_busy", 32'(bus.busy), 32'd0);

        // flip DOWN -> UP, tracking the clip edge every frame
        done_cnt = 0;
        flip();
        chk("f1_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 14; i++) begin
            tick();
            s = exp_shrink[i];
            if (i == 13) chk("f1_done_pulse", 32'(bus.done), 32'd1);
            exp_rgb = (i < 6) ? 1 : (s % 8);
            pix(130 + s, 100);
            chk($sformatf("f1_t%0d_vis", i + 1), 32'(bus.cardon), 32'd1);
            chk($sformatf("f1_t%0d_rgb", i + 1), 32'(bus.rgb), 32'(exp_rgb));
            if (s > 0) begin
                pix(130 + s - 1, 100);
                chk($sformatf("f1_t%0d_clip", i + 1), 32'(bus.cardon), 32'd0);
            end
            if (s == 41) begin
                pix(130 + 42, 100);
                chk("f1_t7_clip_r", 32'(bus.cardon), 32'd0);
            end
        end
        chk("f1_done_count", 32'(done_cnt), 32'd1);
        chk("f1_face_up", 32'(bus.face_up), 32'd1);
        chk("f1_busy_end", 32'(bus.busy), 32'd0);
        pix(135, 70);
        chk("f1_face_c5", 32'(bus.rgb), 32'd5);
        pix(133, 70);
        chk("f1_face_c3", 32'(bus.rgb), 32'd3);
        chk("f1_rom_addr", 32'(bus.rom_addr), 32'd0);

        // flip UP -> DOWN with an extra request during the animation
        done_cnt = 0;
        flip();
        repeat (3) tick();
        flip();
        repeat (10) tick();
        chk("f2_busy_t13", 32'(bus.busy), 32'd1);
        chk("f2_done_t13", 32'(done_cnt), 32'd0);
        tick();
        chk("f2_done_pulse", 32'(bus.done), 32'd1);
        chk("f2_busy_t14", 32'(bus.busy), 32'd0);
        chk("f2_face_up", 32'(bus.face_up), 32'd0);
        @(posedge clk);
        #1;
        chk("f2_done_drop", 32'(bus.done), 32'd0);
        pix(132, 100);
        chk("f2_back_rgb", 32'(bus.rgb), 32'd1);
        chk("f2_done_count", 32'(done_cnt), 32'd1);

        // flip_req with frame_tick together: no shrink step yet
        bus.flip_req = 1'b1;
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.flip_req = 1'b0;
        bus.frame_tick = 1'b0;
        pix(130, 100);
        chk("f3_same_cyc_c0", 32'(bus.cardon), 32'd1);
        chk("f3_busy", 32'(bus.busy), 32'd1);
        repeat (9) tick();
        pix(159, 100);
        chk("f3_t9_vis", 32'(bus.cardon), 32'd1);
        pix(158, 100);
        chk("f3_t9_clip", 32'(bus.cardon), 32'd0);
        pix(159, 100);

        // asynchronous reset mid-flip
        rst_n = 1'b0;
        #1;
        chk("r_busy", 32'(bus.busy), 32'd0);
        chk("r_face_up", 32'(bus.face_up), 32'd0);
        chk("r_cardon", 32'(bus.cardon), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pix(130, 100);
        chk("r_after_c0", 32'(bus.cardon), 32'd1);
        chk("r_after_rgb", 32'(bus.rgb), 32'd1);
        chk("r_after_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
